// File: rtl/icache.sv
// Direct-mapped, one-word-per-line, read-only instruction cache.
// Optional hit/miss statistics counters are built when ICACHE_STAT_EN is defined.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_out_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [31:0]           instr_out_q, instr_out_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]      tag_lat_q, tag_lat_d;
  logic [LINES-1:0]      valid_q;
  logic                  fill_we;

  logic [TAG_W-1:0]      tag_arr [LINES];
  logic [31:0]           data_arr [LINES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic                  unused_pc_lsb;

  // Lookup is purely combinational on the incoming pc; only the result is registered.
  assign lk_idx        = fetch_pc_i[INDEX_BITS+1:2];
  assign lk_tag        = fetch_pc_i[31:INDEX_BITS+2];
  assign lk_hit        = valid_q[lk_idx] && (tag_arr[lk_idx] == lk_tag);
  assign unused_pc_lsb = ^fetch_pc_i[1:0];

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    idx_d         = idx_q;
    tag_lat_d     = tag_lat_q;
    fill_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_req_i) begin
          if (lk_hit) begin
            instr_out_d   = data_arr[lk_idx];
            instr_valid_d = 1'b1;
            state_d       = S_RESP;
          end else begin
            idx_d      = lk_idx;
            tag_lat_d  = lk_tag;
            mem_addr_d = {fetch_pc_i[31:2], 2'b00};
            mem_req_d  = 1'b1;
            state_d    = S_MISS;
          end
        end
      end
      S_MISS: begin
        // The fill finishes regardless of fetch_req; the fetcher absorbs the pulse.
        if (mem_valid_i) begin
          fill_we       = 1'b1;
          instr_out_d   = mem_data_i;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        instr_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: begin
        instr_valid_d = 1'b0;
        mem_req_d     = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      idx_q         <= '0;
      tag_lat_q     <= '0;
      valid_q       <= '0;
    end else if (rdy_i) begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      idx_q         <= idx_d;
      tag_lat_q     <= tag_lat_d;
      if (fill_we) valid_q[idx_q] <= 1'b1;
    end
  end

  // Tag/data storage is never reset; the valid bits gate every lookup.
  always_ff @(posedge clk_i) begin
    if (rdy_i && fill_we) begin
      tag_arr[idx_q]  <= tag_lat_q;
      data_arr[idx_q] <= mem_data_i;
    end
  end

`ifdef ICACHE_STAT_EN
  logic        hit_inc, miss_inc;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign hit_inc  = (state_q == S_IDLE) && fetch_req_i &&  lk_hit;
  assign miss_inc = (state_q == S_IDLE) && fetch_req_i && !lk_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_i) begin
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

  assign instr_valid_o = instr_valid_q;
  assign instr_out_o   = instr_out_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a vector table of fetches plus hand sequences for
// mid-miss drop, rdy stall and asynchronous reset during a fill.
module tb_icache;

`ifdef ICACHE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk, rst, rdy, fetch_req, mem_valid;
  logic [31:0] fetch_pc, mem_data;
  logic        instr_valid, mem_req;
  logic [31:0] instr_out, mem_addr, hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] word;
    int          lat;
  } vec_t;

  vec_t tv [9];

  icache #(.INDEX_BITS(6)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
    .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc),
    .instr_valid_o(instr_valid), .instr_out_o(instr_out),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_valid_i(mem_valid), .mem_data_i(mem_data),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cnt();
    chk("hit_cnt",  hit_cnt,  STAT ? 32'(exp_hits)   : 32'd0);
    chk("miss_cnt", miss_cnt, STAT ? 32'(exp_misses) : 32'd0);
  endtask

  // One complete fetch; on a miss the memory answers lat cycles after mem_req rises.
  task automatic run_fetch(input logic [31:0] pc, input logic hit,
                           input logic [31:0] word, input int lat);
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    @(posedge clk); #1;
    if (hit) begin
      exp_hits++;
      chk("hit_valid", {31'd0, instr_valid}, 32'd1);
      chk("hit_data",  instr_out, word);
      chk("hit_noreq", {31'd0, mem_req}, 32'd0);
    end else begin
      exp_misses++;
      chk("miss_req",   {31'd0, mem_req}, 32'd1);
      chk("miss_addr",  mem_addr, {pc[31:2], 2'b00});
      chk("miss_noval", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      fetch_req = 1'b0;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("miss_wait_req", {31'd0, mem_req}, 32'd1);
        chk("miss_wait_val", {31'd0, instr_valid}, 32'd0);
      end
      mem_valid = 1'b1;
      mem_data  = word;
      @(posedge clk); #1;
      chk("fill_valid", {31'd0, instr_valid}, 32'd1);
      chk("fill_data",  instr_out, word);
      chk("fill_reqlo", {31'd0, mem_req}, 32'd0);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_end", {31'd0, instr_valid}, 32'd0);
    chk_cnt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    // 0x100, 0x200, 0x400, 0x500 share index 0; 0x104/0x107 index 1; 0x20B index 2.
    tv[0] = '{32'h0000_0100, 1'b0, 32'h00A0_0093, 3};
    tv[1] = '{32'h0000_0100, 1'b1, 32'h00A0_0093, 0};
    tv[2] = '{32'h0000_0200, 1'b0, 32'h1111_1111, 2};
    tv[3] = '{32'h0000_0100, 1'b0, 32'h00A0_0093, 1};
    tv[4] = '{32'h0000_0104, 1'b0, 32'h2222_2222, 0};
    tv[5] = '{32'h0000_0104, 1'b1, 32'h2222_2222, 0};
    tv[6] = '{32'h0000_0200, 1'b0, 32'h1111_1111, 4};
    tv[7] = '{32'h0000_0107, 1'b1, 32'h2222_2222, 0};
    tv[8] = '{32'h0000_020B, 1'b0, 32'h3333_3333, 1};

    rst = 1'b1; rdy = 1'b1; fetch_req = 1'b0; fetch_pc = '0;
    mem_valid = 1'b0; mem_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_out",   instr_out, 32'd0);
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk_cnt();

    foreach (tv[i]) run_fetch(tv[i].pc, tv[i].hit, tv[i].word, tv[i].lat);

    // Request dropped and pc changed while the fill is outstanding.
    @(negedge clk);
    fetch_req = 1'b1; fetch_pc = 32'h0000_0400;
    @(posedge clk); #1;
    exp_misses++;
    chk("drop_req",  {31'd0, mem_req}, 32'd1);
    chk("drop_addr", mem_addr, 32'h0000_0400);
    @(negedge clk);
    fetch_req = 1'b0; fetch_pc = 32'h0000_0300;
    repeat (2) begin
      @(negedge clk);
      chk("drop_hold_addr", mem_addr, 32'h0000_0400);
      chk("drop_hold_val",  {31'd0, instr_valid}, 32'd0);
    end
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("drop_fill_val",  {31'd0, instr_valid}, 32'd1);
    chk("drop_fill_data", instr_out, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("drop_single_pulse", {31'd0, instr_valid}, 32'd0);
      chk("drop_no_new_req",   {31'd0, mem_req}, 32'd0);
    end
    // Stray mem_valid in IDLE must be ignored.
    @(negedge clk);
    mem_valid = 1'b1; mem_data = 32'h1234_5678;
    @(posedge clk); #1;
    chk("stray_val",  {31'd0, instr_valid}, 32'd0);
    chk("stray_keep", instr_out, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_valid = 1'b0;
    chk_cnt();
    run_fetch(32'h0000_0400, 1'b1, 32'hDEAD_BEEF, 0);

    // rdy stall during a hit response.
    @(negedge clk);
    fetch_req = 1'b1; fetch_pc = 32'h0000_0400;
    @(posedge clk); #1;
    exp_hits++;
    chk("stall_valid0", {31'd0, instr_valid}, 32'd1);
    @(negedge clk);
    fetch_req = 1'b0; rdy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_data",  instr_out, 32'hDEAD_BEEF);
    end
    chk_cnt();
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {31'd0, instr_valid}, 32'd0);
    chk_cnt();

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    fetch_req = 1'b1; fetch_pc = 32'h0000_0500;
    @(posedge clk); #1;
    chk("arst_req_pre", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   {31'd0, mem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_addr",  mem_addr, 32'd0);
    exp_hits = 0; exp_misses = 0;
    chk_cnt();
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_valid = 1'b1; mem_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    chk("arst_late_fill", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    run_fetch(32'h0000_0500, 1'b0, 32'h5555_5555, 2);
    run_fetch(32'h0000_0104, 1'b0, 32'h2222_2222, 1);
    run_fetch(32'h0000_0500, 1'b1, 32'h5555_5555, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
